// File: rtl/calc1_port_scheduler.sv
// calc1_port_scheduler: four calc1 two-cycle ports sharing one pipelined add/sub/shift ALU.
// Define CALC_FIXED_PRIO_EN for fixed priority (port1 highest) instead of round-robin.
module calc1_port_scheduler #(
    parameter int ALU_LAT = 2,
    parameter int RR_INIT = 0
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:3]  busy
);
    typedef enum logic [1:0] {IDLE, OP2, PEND, EXEC} state_t;
    typedef struct packed {
        logic        v;
        logic [1:0]  port;
        logic [1:0]  resp;
        logic [31:0] data;
    } slot_t;

    state_t      st [4];
    logic [3:0]  cmd_in [4];
    logic [3:0]  cmd_q [4];
    logic [31:0] din [4];
    logic [31:0] a_q [4];
    logic [31:0] b_q [4];
    logic [31:0] data_q [4];
    logic [1:0]  resp_q [4];
    logic [1:0]  ptr;
    logic [1:0]  gnt;
    logic        gnt_v;
    slot_t       pipe [ALU_LAT];
    slot_t       issue;
    slot_t       done;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [32:0] sum;
    logic        err;

    function automatic logic valid_cmd(input logic [3:0] cmd);
        return cmd inside {4'd1, 4'd2, 4'd5, 4'd6};
    endfunction

    assign cmd_in    = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
    assign din       = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data1 = data_q[0];
    assign out_data2 = data_q[1];
    assign out_data3 = data_q[2];
    assign out_data4 = data_q[3];
    assign busy      = {st[0] != IDLE, st[1] != IDLE, st[2] != IDLE, st[3] != IDLE};
    assign done      = pipe[ALU_LAT-1];

`ifdef CALC_FIXED_PRIO_EN
    assign ptr = 2'd0;
`else
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= 2'(RR_INIT);
        else if (gnt_v)
            ptr <= gnt + 2'd1;
    end
`endif

    // Scan from the highest-offset candidate down so the port nearest ptr wins.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (st[ptr + 2'(i)] == PEND) begin
                gnt_v = 1'b1;
                gnt   = ptr + 2'(i);
            end
    end

    always_comb begin
        a          = a_q[gnt];
        b          = b_q[gnt];
        c          = cmd_q[gnt];
        sum        = {1'b0, a} + {1'b0, b};
        err        = (c == 4'd1 && sum[32]) || (c == 4'd2 && b > a);
        issue.v    = gnt_v;
        issue.port = gnt;
        issue.resp = err ? 2'd2 : 2'd1;
        issue.data = err ? '0 : c == 4'd1 ? sum[31:0] : c == 4'd2 ? a - b :
                     c == 4'd5 ? a << b[4:0] : a >> b[4:0];
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                st[k]     <= IDLE;
                cmd_q[k]  <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                resp_q[k] <= '0;
                data_q[k] <= '0;
            end
            for (int i = 0; i < ALU_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < ALU_LAT; i++)
                pipe[i] <= pipe[i-1];
            for (int k = 0; k < 4; k++) begin
                resp_q[k] <= '0;
                data_q[k] <= '0;
                case (st[k])
                    IDLE: if (cmd_in[k] != '0) begin
                        st[k]    <= OP2;
                        cmd_q[k] <= cmd_in[k];
                        a_q[k]   <= din[k];
                    end
                    OP2: begin
                        b_q[k]    <= din[k];
                        st[k]     <= valid_cmd(cmd_q[k]) ? PEND : IDLE;
                        resp_q[k] <= valid_cmd(cmd_q[k]) ? 2'd0 : 2'd2;
                    end
                    PEND: if (gnt_v && gnt == 2'(k))
                        st[k] <= EXEC;
                    EXEC: if (done.v && done.port == 2'(k)) begin
                        st[k]     <= IDLE;
                        resp_q[k] <= done.resp;
                        data_q[k] <= done.data;
                    end
                    default: st[k] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc1_port_scheduler.sv
// tb_calc1_port_scheduler: randomized and directed stimulus, timing-level reference model, scoreboard monitor.
module tb_calc1_port_scheduler;
    localparam int ALU_LAT = 2;
    localparam int RR_INIT = 0;
    localparam int BIG     = 32'h7fff_ffff;

    typedef struct packed {int cyc; logic [1:0] resp; logic [31:0] data;} exp_t;
    typedef struct packed {int port; int elig; logic [1:0] resp; logic [31:0] data;} pend_t;

    logic        c_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  cmd_d [4];
    logic [31:0] data_d [4];
    logic [1:0]  resp_o [4];
    logic [31:0] dout [4];
    logic [0:3]  busy;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t        sb [4][$];
    pend_t       pend [$];
    int          free_at [4];
    int          acc_at [4];
    bit          op2p [4];
    logic [3:0]  pc [4];
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    int          mptr;
    bit          in_rst = 1'b0;
    logic [3:0]  want_cmd [4];
    logic [31:0] want_a [4];
    logic [31:0] want_b [4];

    calc1_port_scheduler #(.ALU_LAT(ALU_LAT), .RR_INIT(RR_INIT)) dut (
        .c_clk(c_clk), .reset_n(reset_n),
        .req1_cmd_in(cmd_d[0]), .req2_cmd_in(cmd_d[1]), .req3_cmd_in(cmd_d[2]), .req4_cmd_in(cmd_d[3]),
        .req1_data_in(data_d[0]), .req2_data_in(data_d[1]), .req3_data_in(data_d[2]), .req4_data_in(data_d[3]),
        .out_resp1(resp_o[0]), .out_resp2(resp_o[1]), .out_resp3(resp_o[2]), .out_resp4(resp_o[3]),
        .out_data1(dout[0]), .out_data2(dout[1]), .out_data3(dout[2]), .out_data4(dout[3]),
        .busy(busy)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    function automatic bit is_valid(input logic [3:0] c);
        return c == 1 || c == 2 || c == 5 || c == 6;
    endfunction

    function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [1:0] r, output logic [31:0] d);
        logic [63:0] s;
        int sh;
        sh = int'(b % 32);
        r  = 2'd1;
        d  = '0;
        s  = 64'(a) + 64'(b);
        case (c)
            4'd1: if (s > 64'hFFFF_FFFF) r = 2'd2; else d = s[31:0];
            4'd2: if (b > a) r = 2'd2; else d = a - b;
            4'd5: d = a << sh;
            4'd6: d = a >> sh;
            default: r = 2'd2;
        endcase
    endfunction

    function automatic void flush();
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            free_at[k] = 0;
            acc_at[k]  = -1;
            op2p[k]    = 1'b0;
        end
        pend.delete();
        mptr = RR_INIT;
    endfunction

    function automatic void arbitrate(input int n);
        int p;
        for (int i = 0; i < 4; i++) begin
`ifdef CALC_FIXED_PRIO_EN
            p = i;
`else
            p = (mptr + i) % 4;
`endif
            foreach (pend[j])
                if (pend[j].port == p && pend[j].elig <= n) begin
                    sb[p].push_back('{n + ALU_LAT + 1, pend[j].resp, pend[j].data});
                    free_at[p] = n + ALU_LAT + 1;
                    mptr = (p + 1) % 4;
                    pend.delete(j);
                    return;
                end
        end
    endfunction

    // One cycle: drive inputs at the falling edge and advance the reference model.
    task automatic tick();
        int n;
        bit eb;
        logic [1:0] r;
        logic [31:0] d;
        @(negedge c_clk);
        n = cyc;
        for (int k = 0; k < 4; k++) begin
            if (!in_rst) begin
                eb = acc_at[k] >= 0 && acc_at[k] < n && n < free_at[k];
                checks++;
                if (busy[k] !== eb) begin
                    errors++;
                    $display("FAIL busy port%0d cycle %0d: got %b want %b", k + 1, n, busy[k], eb);
                end
            end
            if (in_rst) begin
                cmd_d[k]  = 4'($urandom_range(1, 15));
                data_d[k] = $urandom;
            end else if (op2p[k]) begin
                cmd_d[k]  = 4'($urandom_range(0, 15));
                data_d[k] = pb[k];
                op2p[k]   = 1'b0;
                ref_alu(pc[k], pa[k], pb[k], r, d);
                if (!is_valid(pc[k])) begin
                    sb[k].push_back('{n + 1, r, d});
                    free_at[k] = n + 1;
                end else
                    pend.push_back('{k, n + 1, r, d});
            end else begin
                cmd_d[k]  = want_cmd[k];
                data_d[k] = want_cmd[k] != 0 ? want_a[k] : $urandom;
                if (want_cmd[k] != 0 && n >= free_at[k]) begin
                    acc_at[k]  = n;
                    free_at[k] = BIG;
                    op2p[k]    = 1'b1;
                    pc[k]      = want_cmd[k];
                    pa[k]      = want_a[k];
                    pb[k]      = want_b[k];
                end
            end
            want_cmd[k] = '0;
        end
        if (!in_rst) arbitrate(n);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic want(input int k, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        want_cmd[k] = c;
        want_a[k]   = a;
        want_b[k]   = b;
    endtask

    task automatic do_reset(input int n);
        @(posedge c_clk);
        #2;
        reset_n = 1'b0;
        in_rst  = 1'b1;
        flush();
        repeat (n) tick();
        for (int k = 0; k < 4; k++) cmd_d[k] = '0;
        @(negedge c_clk);
        reset_n = 1'b1;
        in_rst  = 1'b0;
    endtask

    function automatic bit all_free();
        for (int k = 0; k < 4; k++)
            if (op2p[k] || free_at[k] > cyc + 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_busy();
        if (pend.size() != 0) return 1'b1;
        for (int k = 0; k < 4; k++)
            if (op2p[k] || sb[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 40));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_cmd();
        case ($urandom_range(0, 9))
            0, 1: return 4'd1;
            2, 3: return 4'd2;
            4, 5: return 4'd5;
            6, 7: return 4'd6;
            default: return 4'($urandom_range(1, 15));
        endcase
    endfunction

    always @(negedge c_clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (!reset_n) begin
                checks++;
                if (resp_o[k] !== 0 || dout[k] !== 0 || busy[k] !== 0) begin
                    errors++;
                    $display("FAIL reset port%0d: got resp=%0d data=%h busy=%b, want all zero",
                             k + 1, resp_o[k], dout[k], busy[k]);
                end
            end else begin
                while (sb[k].size() > 0 && sb[k][0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing port%0d: got no response at cycle %0d, want resp=%0d data=%h",
                             k + 1, sb[k][0].cyc, sb[k][0].resp, sb[k][0].data);
                    void'(sb[k].pop_front());
                end
                if (resp_o[k] !== 0) begin
                    checks++;
                    if (sb[k].size() == 0 || sb[k][0].cyc != cyc) begin
                        errors++;
                        $display("FAIL unexpected port%0d cycle %0d: got resp=%0d data=%h, want no response",
                                 k + 1, cyc, resp_o[k], dout[k]);
                    end else begin
                        e = sb[k].pop_front();
                        if (resp_o[k] !== e.resp || dout[k] !== e.data) begin
                            errors++;
                            $display("FAIL result port%0d cycle %0d: got resp=%0d data=%h, want resp=%0d data=%h",
                                     k + 1, cyc, resp_o[k], dout[k], e.resp, e.data);
                        end
                    end
                end else if (dout[k] !== 0) begin
                    checks++;
                    errors++;
                    $display("FAIL idle_data port%0d cycle %0d: got data=%h, want 0", k + 1, cyc, dout[k]);
                end
            end
        end
    end

    initial begin
        int guard;
        logic [31:0] x;
        for (int k = 0; k < 4; k++) begin
            cmd_d[k]    = '0;
            data_d[k]   = '0;
            want_cmd[k] = '0;
        end
        flush();
        do_reset(4);
        idle(3);
        want(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
        tick();
        idle(8);
        want(1, 4'd1, 32'hFFFF_FFFF, 32'h1);
        want(2, 4'd2, 32'd3, 32'd5);
        want(3, 4'd5, 32'h1, 32'h21);
        tick();
        idle(10);
        want(2, 4'd2, 32'd5, 32'd5);
        want(3, 4'd6, 32'h8000_0000, 32'd31);
        tick();
        idle(8);
        want(0, 4'd3, 32'h1, 32'h2);
        want(1, 4'd1, 32'd10, 32'd20);
        tick();
        idle(8);
        for (int r = 0; r < 3; r++) begin
            guard = 0;
            while (!all_free() && guard < 50) begin
                tick();
                guard++;
            end
            checks++;
            if (!all_free()) begin
                errors++;
                $display("FAIL contention_wait: got ports still busy, want all idle within 50 cycles");
            end
            for (int k = 0; k < 4; k++) want(k, 4'd1, $urandom, $urandom);
            tick();
        end
        idle(20);
        repeat (400) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) begin
                    x = rnd_op();
                    want(k, rnd_cmd(), x, $urandom_range(0, 7) == 0 ? x : rnd_op());
                end
            tick();
        end
        for (int k = 0; k < 4; k++) want(k, 4'd1, $urandom, $urandom);
        tick();
        idle(3);
        do_reset(2);
        idle(12);
        repeat (100) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 0) want(k, rnd_cmd(), rnd_op(), rnd_op());
            tick();
        end
        guard = 0;
        while (model_busy() && guard < 200) begin
            tick();
            guard++;
        end
        for (int k = 0; k < 4; k++)
            foreach (sb[k][j]) begin
                checks++;
                errors++;
                $display("FAIL drain port%0d: got nothing by end, want resp=%0d data=%h at cycle %0d",
                         k + 1, sb[k][j].resp, sb[k][j].data, sb[k][j].cyc);
            end
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
